// File: rtl/sipo_pkg.sv
// sipo_pkg: shared FSM state type and bit-counter width helper for the deserializer
package sipo_pkg;

    typedef enum logic {FILL, HOLD} state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial input, framing controls and valid/ready word output
interface sipo_deserializer_if #(parameter int WIDTH = 8);

    logic                               din;
    logic                               din_en;
    logic                               sync;
    logic                               dout_ready;
    logic                               clr_ovf;
    logic [WIDTH-1:0]                   dout;
    logic                               dout_valid;
    logic [sipo_pkg::cnt_w(WIDTH)-1:0]  bit_cnt;
    logic                               overflow;

    modport master (
        output din, din_en, sync, dout_ready, clr_ovf,
        input  dout, dout_valid, bit_cnt, overflow
    );

    modport slave (
        input  din, din_en, sync, dout_ready, clr_ovf,
        output dout, dout_valid, bit_cnt, overflow
    );

endinterface

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: shift register and bit counter; flags the cycle a full word is available on word
module sipo_shift_reg import sipo_pkg::*; #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    input  logic                      din_en,
    input  logic                      sync,
    output logic [WIDTH-1:0]          word,
    output logic                      complete,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);

    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] first;

    // word is the next shift value, so the completion candidate already contains the current din
    assign word     = MSB_FIRST ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};
    assign first    = MSB_FIRST ? {{(WIDTH-1){1'b0}}, din} : {din, {(WIDTH-1){1'b0}}};
    assign complete = din_en & ~sync & (bit_cnt == CW'(WIDTH-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (sync) begin
            sr      <= din_en ? first : '0;
            bit_cnt <= din_en ? CW'(1) : '0;
        end else if (din_en) begin
            sr      <= word;
            bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-to-parallel word assembly with valid/ready holding register and sticky overflow
module sipo_deserializer import sipo_pkg::*; #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    sipo_deserializer_if.slave  bus
);

    logic [WIDTH-1:0] word;
    logic             complete;
    logic             accept;
    state_t           state;

    sipo_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .din      (bus.din),
        .din_en   (bus.din_en),
        .sync     (bus.sync),
        .word     (word),
        .complete (complete),
        .bit_cnt  (bus.bit_cnt)
    );

    assign accept = bus.dout_valid & bus.dout_ready;

    // a word completing while the previous one is still unconsumed is dropped, never overwrites dout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= FILL;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            if (complete && (state == FILL || accept)) begin
                state          <= HOLD;
                bus.dout       <= word;
                bus.dout_valid <= 1'b1;
            end else if (accept) begin
                state          <= FILL;
                bus.dout_valid <= 1'b0;
            end
            bus.overflow <= (complete & (state == HOLD) & ~accept) | (bus.overflow & ~bus.clr_ovf);
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed and random stimulus against a frame-level model, checked by a scoreboard monitor
module tb_sipo_deserializer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic din = 1'b0, din_en = 1'b0, sync = 1'b0, ready = 1'b0, clr = 1'b0;

    int checks = 0;
    int failures = 0;

    bit       frame[$];
    bit [7:0] qa[$];
    bit [7:0] qb[$];
    bit       mvalid = 1'b0;
    bit       movf = 1'b0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(W)) ia ();
    sipo_deserializer_if #(.WIDTH(W)) ib ();

    assign ia.din = din;   assign ib.din = din;
    assign ia.din_en = din_en; assign ib.din_en = din_en;
    assign ia.sync = sync; assign ib.sync = sync;
    assign ia.dout_ready = ready; assign ib.dout_ready = ready;
    assign ia.clr_ovf = clr; assign ib.clr_ovf = clr;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .reset(reset), .bus(ia.slave));
    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .reset(reset), .bus(ib.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: frame kept as a list of received bits, words built arithmetically
    always @(posedge clk or negedge reset) begin
        bit acc, cmp, drop;
        bit [7:0] wa, wb;
        if (!reset) begin
            frame.delete(); qa.delete(); qb.delete();
            mvalid = 1'b0;
            movf = 1'b0;
        end else begin
            acc = mvalid && ready;
            cmp = 1'b0;
            wa = '0;
            wb = '0;
            if (sync) begin
                frame.delete();
                if (din_en) frame.push_back(din);
            end else if (din_en) begin
                frame.push_back(din);
                if (frame.size() == W) begin
                    cmp = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        wa += 8'(frame[i]) << (W - 1 - i);
                        wb += 8'(frame[i]) << i;
                    end
                    frame.delete();
                end
            end
            drop = cmp && mvalid && !acc;
            if (cmp && !drop) begin
                qa.push_back(wa);
                qb.push_back(wb);
                mvalid = 1'b1;
            end else if (acc) begin
                mvalid = 1'b0;
            end
            movf = drop ? 1'b1 : (clr ? 1'b0 : movf);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("valid_msb", ia.dout_valid, mvalid);
            chk("valid_lsb", ib.dout_valid, mvalid);
            chk("overflow", ia.overflow, movf);
            chk("bit_cnt", ia.bit_cnt, frame.size());
            if (ia.dout_valid) begin
                if (qa.size() == 0) chk("dout_msb_unexpected", ia.dout_valid, 1'b0);
                else begin
                    chk("dout_msb", ia.dout, qa[0]);
                    if (ready) void'(qa.pop_front());
                end
            end
            if (ib.dout_valid) begin
                if (qb.size() == 0) chk("dout_lsb_unexpected", ib.dout_valid, 1'b0);
                else begin
                    chk("dout_lsb", ib.dout, qb[0]);
                    if (ready) void'(qb.pop_front());
                end
            end
        end
    end

    task automatic step(input logic d, input logic en, input logic s, input logic r, input logic c);
        din = d; din_en = en; sync = s; ready = r; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic r);
        for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0, r, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dout"}, ia.dout, 8'h00);
        chk({tag, "_valid"}, ia.dout_valid, 1'b0);
        chk({tag, "_ovf"}, ia.overflow, 1'b0);
        chk({tag, "_cnt"}, ia.bit_cnt, 3'd0);
    endtask

    initial begin
        #3;
        chk_reset_state("por");
        @(posedge clk); #1;
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        send_word(8'hB2, 1'b1);
        chk("t1_dout_msb", ia.dout, 8'hB2);
        chk("t1_dout_lsb", ib.dout, 8'h4D);
        chk("t1_valid", ia.dout_valid, 1'b1);
        chk("t1_cnt", ia.bit_cnt, 3'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = W - 1; i >= 0; i--) begin
            logic [7:0] v = 8'hB2;
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            step(v[i], 1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("t2_dout_lsb", ib.dout, 8'h4D);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        send_word(8'hB2, 1'b0);
        send_word(8'hFF, 1'b0);
        chk("t3_dout", ia.dout, 8'hB2);
        chk("t3_ovf_set", ia.overflow, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_ovf_clr", ia.overflow, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_valid_drop", ia.dout_valid, 1'b0);

        send_word(8'h5A, 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            logic [7:0] v = 8'h3C;
            step(v[i], 1'b1, 1'b0, i == 0, 1'b0);
        end
        chk("t4_dout", ia.dout, 8'h3C);
        chk("t4_valid", ia.dout_valid, 1'b1);
        chk("t4_ovf", ia.overflow, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_cnt_after_sync", ia.bit_cnt, 3'd1);
        for (int i = 6; i >= 0; i--) begin
            logic [7:0] v = 8'hB2;
            step(v[i], 1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("t5_dout", ia.dout, 8'hB2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        send_word(8'h77, 1'b0);
        #2 reset = 1'b0;
        #1 chk_reset_state("t6_hold");
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 chk_reset_state("t6_mid");
        @(posedge clk); #1;
        reset = 1'b1;
        send_word(8'hC3, 1'b1);
        chk("t6_dout", ia.dout, 8'hC3);
        chk("t6_valid", ia.dout_valid, 1'b1);

        for (int i = 0; i < 3000; i++)
            step(1'($urandom), $urandom_range(9) < 7, $urandom_range(99) < 3,
                 1'($urandom), $urandom_range(99) < 5);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain_msb", qa.size(), 0);
        chk("drain_lsb", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
